lstm_bp_ctrl: RTL and testbench
===============================

Name: lstm_bp_ctrl

Overview:
Sequencer for the LSTM backpropagation datapath `bp`, which is combinational.
- Collects TIMESTEP forward-pass samples over a valid/ready stream and packs them into the `bp` timestep buses.
- Waits a programmable settle time, then applies an SGD update (w <= w - lr*grad) to all four gate weight vectors and biases, using one shared fixed-point multiplier.
- Holds the live weights and biases, which also drive the `bp` weight inputs.

Parameters:
- WIDTH, 32, fixed-point word width
- FRAC, 24, fractional bits
- TIMESTEP, 2, samples per backprop window
- NUM, 3, inputs per gate (inputs + previous output)
- SETTLE, 4, cycles allowed for `bp` combinational settling (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_wload  in  1  load initial weights/biases (IDLE only)
- i_wa_init, i_wi_init, i_wf_init, i_wo_init  in  NUM*WIDTH  initial gate weights
- i_b_init  in  4*WIDTH  initial biases, {o,f,i,a}
- i_lr  in  WIDTH  learning rate, sampled at i_start
- i_start  in  1  begin window
- i_valid  in  1  sample valid
- o_ready  out  1  accepting samples
- i_x_s  in  NUM*WIDTH  sample input vector
- i_t_s, i_h_s, i_c_s, i_a_s, i_i_s, i_f_s, i_o_s  in  WIDTH  sample target/state/gate values
- o_x  out  TIMESTEP*NUM*WIDTH  packed to `bp`
- o_t, o_h, o_c, o_a, o_i, o_f, o_o  out  TIMESTEP*WIDTH  packed to `bp`
- i_gb  in  4*WIDTH  bias gradients from `bp`, {o,f,i,a}
- i_gwa, i_gwi, i_gwf, i_gwo  in  NUM*WIDTH  weight gradients from `bp`
- o_wa, o_wi, o_wf, o_wo  out  NUM*WIDTH  current weights
- o_b  out  4*WIDTH  current biases
- o_busy  out  1  window in progress
- o_done  out  1  one-cycle pulse after update

Behaviour:
- Reset: state IDLE.
  - All packed buffers, weights and biases are 0; lr register is 0.
  - o_ready=0, o_busy=0, o_done=0.
- IDLE:
  - i_wload=1 copies the *_init ports into the weight/bias registers next edge.
  - i_start=1 latches i_lr, clears the sample counter and goes to LOAD. i_start wins if asserted together with i_wload.
- LOAD:
  - o_ready=1. A sample is accepted on a cycle with i_valid&o_ready.
  - Sample k (0-based) is written to slice k: bits [(k+1)*W-1 : k*W] of o_t etc., and [(k+1)*NUM*W-1 : k*NUM*W] of o_x. Timestep 0 sits in the LSBs.
  - After sample TIMESTEP-1 is accepted: o_ready drops the next cycle and the state goes to SETTLE.
  - i_valid without o_ready is ignored. i_start outside IDLE is ignored.
- SETTLE: a countdown of SETTLE cycles; buffers and weights are held stable. Then go to UPDATE.
- UPDATE:
  - Gradients are snapshotted into a shadow register on the first UPDATE cycle, so weight changes feeding back into `bp` cannot corrupt later elements.
  - One element is updated per cycle over 4*(NUM+1) elements, in this order: wa[0..NUM-1], wi, wf, wo, then ba, bi, bf, bo.
  - Element index 0 is the LSB slice.
- Arithmetic:
  - p = signed 2W-bit product lr*g, arithmetic-shifted right by FRAC (truncation toward -inf).
  - w' = w - p[W-1:0], with two's-complement wrap.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_busy=1 in LOAD, SETTLE and UPDATE.
- Latency: i_start to o_done = 1 + TIMESTEP (no stalls) + SETTLE + 4*(NUM+1) + 1 cycles.
- Reset mid-window aborts immediately to reset values, including weights; software must reload weights afterwards.
- The packed buffers keep their last window's contents after DONE.

Optional Feature:
- LSTM_BP_SAT_EN defined:
  - The shifted product is saturated to [-2^(W-1), 2^(W-1)-1] before subtraction.
  - The subtraction also saturates instead of wrapping.
- LSTM_BP_SAT_EN undefined: two's-complement wrap as above.

Decomposition:
- Shared package lstm_pkg holds:
  - state encoding enum (IDLE, LOAD, SETTLE, UPDATE, DONE)
  - WIDTH/FRAC defaults
  - gate index constants (A=0, I=1, F=2, O=3)
  - a fixed-point multiply-shift function
- One sub-module: fxp_mac_sub, the shared multiply/shift/subtract unit with optional saturation.

Test Plan:
- Load and pack:
  - Stimulus: i_wload, then i_start; TIMESTEP=2 samples with i_t_s 0x00800000 then 0x01400000.
  - Expected: o_t = 0x01400000_00800000; o_ready=0 after the 2nd accept.
- Single update:
  - Stimulus: lr=0x00100000, wa[0]=0x00800000, gwa[0]=0x01000000.
  - Expected: wa[0]=0x00700000 after o_done; an all-zero gradient leaves every other element unchanged.
- Timing:
  - Stimulus: NUM=3, SETTLE=4, valid held high.
  - Expected: o_done exactly 1+2+4+16+1=24 cycles after i_start, and width of 1 cycle.
- Backpressure:
  - Stimulus: i_valid gaps during LOAD; i_start pulsed while busy.
  - Expected: only handshaked samples are stored; the i_start is ignored.
- Saturation:
  - Stimulus: lr=0x7FFFFFFF, g=0x7FFFFFFF, w=0x80000000.
  - Expected: result 0x80000000 with LSTM_BP_SAT_EN; the wrapped value without it.
- Reset mid-UPDATE:
  - Stimulus: assert rst during UPDATE.
  - Expected: immediately all outputs 0, state IDLE, no o_done.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM backprop sequencer: FSM state encoding,
// default fixed-point format, gate indices and the fixed-point multiply-shift.
package lstm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_UPDATE,
    ST_DONE
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 24;

  // Gate order inside every packed weight/bias group
  localparam int GATE_A = 0;
  localparam int GATE_I = 1;
  localparam int GATE_F = 2;
  localparam int GATE_O = 3;

  // Operands are sign-extended to MUL_W bits; supports word widths below MUL_W
  localparam int MUL_W = 64;

  // Signed product of a and b, arithmetic-shifted right by frac (floor toward -inf)
  function automatic logic signed [2*MUL_W-1:0] fxp_mul_shift(
    input logic signed [MUL_W-1:0] a,
    input logic signed [MUL_W-1:0] b,
    input int unsigned             frac
  );
    logic signed [2*MUL_W-1:0] p;
    p = $signed({{MUL_W{a[MUL_W-1]}}, a}) * $signed({{MUL_W{b[MUL_W-1]}}, b});
    return p >>> frac;
  endfunction

endpackage

// File: rtl/fxp_mac_sub.sv
// Shared SGD element unit: o_w = i_w - ((i_lr * i_g) >>> FRAC).
// Build option LSTM_BP_SAT_EN: saturate the shifted product and the
// subtraction instead of two's-complement wrapping.
module fxp_mac_sub
  import lstm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic [WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0] i_lr,
  input  logic [WIDTH-1:0] i_g,
  output logic [WIDTH-1:0] o_w
);

  localparam int PW = 2 * MUL_W;

  logic signed [MUL_W-1:0] lr_ext;
  logic signed [MUL_W-1:0] g_ext;
  logic signed [PW-1:0]    prod;

  assign lr_ext = {{(MUL_W-WIDTH){i_lr[WIDTH-1]}}, i_lr};
  assign g_ext  = {{(MUL_W-WIDTH){i_g[WIDTH-1]}}, i_g};
  assign prod   = fxp_mul_shift(lr_ext, g_ext, FRAC);

`ifdef LSTM_BP_SAT_EN
  localparam logic signed [PW-1:0] P_MAX = $signed({{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] P_MIN = $signed({{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

  logic [WIDTH-1:0]    p_sat;
  logic signed [WIDTH:0] diff;

  // Clamp the product to the word range, then subtract with one guard bit and clamp again
  always_comb begin
    if (prod > P_MAX)      p_sat = P_MAX[WIDTH-1:0];
    else if (prod < P_MIN) p_sat = P_MIN[WIDTH-1:0];
    else                   p_sat = prod[WIDTH-1:0];
    diff = $signed({i_w[WIDTH-1], i_w}) - $signed({p_sat[WIDTH-1], p_sat});
    if (diff[WIDTH] != diff[WIDTH-1])
      o_w = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      o_w = diff[WIDTH-1:0];
  end
`else
  // Only the low word of the product matters once the subtraction wraps
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[PW-1:WIDTH];
  assign o_w = i_w - prod[WIDTH-1:0];
`endif

endmodule

// File: rtl/lstm_bp_ctrl.sv
// Sequencer for the combinational LSTM backprop datapath: gathers TIMESTEP
// samples, waits SETTLE cycles, snapshots gradients, then applies one SGD
// element update per cycle through a shared fxp_mac_sub.
// Build option LSTM_BP_SAT_EN selects saturating arithmetic in fxp_mac_sub.
//
// Sample handshake: a sample transfers on a rising edge where i_valid and
// o_ready are both high; o_ready is high only in LOAD, i_valid alone is ignored.
module lstm_bp_ctrl
  import lstm_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int TIMESTEP = 2,
  parameter int NUM      = 3,
  parameter int SETTLE   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wload,
  input  logic [NUM*WIDTH-1:0]         i_wa_init,
  input  logic [NUM*WIDTH-1:0]         i_wi_init,
  input  logic [NUM*WIDTH-1:0]         i_wf_init,
  input  logic [NUM*WIDTH-1:0]         i_wo_init,
  input  logic [4*WIDTH-1:0]           i_b_init,
  input  logic [WIDTH-1:0]             i_lr,
  input  logic                         i_start,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [NUM*WIDTH-1:0]         i_x_s,
  input  logic [WIDTH-1:0]             i_t_s,
  input  logic [WIDTH-1:0]             i_h_s,
  input  logic [WIDTH-1:0]             i_c_s,
  input  logic [WIDTH-1:0]             i_a_s,
  input  logic [WIDTH-1:0]             i_i_s,
  input  logic [WIDTH-1:0]             i_f_s,
  input  logic [WIDTH-1:0]             i_o_s,
  output logic [TIMESTEP*NUM*WIDTH-1:0] o_x,
  output logic [TIMESTEP*WIDTH-1:0]    o_t,
  output logic [TIMESTEP*WIDTH-1:0]    o_h,
  output logic [TIMESTEP*WIDTH-1:0]    o_c,
  output logic [TIMESTEP*WIDTH-1:0]    o_a,
  output logic [TIMESTEP*WIDTH-1:0]    o_i,
  output logic [TIMESTEP*WIDTH-1:0]    o_f,
  output logic [TIMESTEP*WIDTH-1:0]    o_o,
  input  logic [4*WIDTH-1:0]           i_gb,
  input  logic [NUM*WIDTH-1:0]         i_gwa,
  input  logic [NUM*WIDTH-1:0]         i_gwi,
  input  logic [NUM*WIDTH-1:0]         i_gwf,
  input  logic [NUM*WIDTH-1:0]         i_gwo,
  output logic [NUM*WIDTH-1:0]         o_wa,
  output logic [NUM*WIDTH-1:0]         o_wi,
  output logic [NUM*WIDTH-1:0]         o_wf,
  output logic [NUM*WIDTH-1:0]         o_wo,
  output logic [4*WIDTH-1:0]           o_b,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int NEL  = 4 * (NUM + 1);     // weights then biases, one element per cycle
  localparam int GW   = NUM * WIDTH;
  localparam int PV_W = NEL * WIDTH;
  localparam int MAXC = (NEL > SETTLE) ? ((NEL > TIMESTEP) ? NEL : TIMESTEP)
                                       : ((SETTLE > TIMESTEP) ? SETTLE : TIMESTEP);
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TS_LAST = CW'(TIMESTEP - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] EL_LAST = CW'(NEL - 1);

  // Parameter vector layout, element e at [e*WIDTH +: WIDTH]: {b(o,f,i,a), wo, wf, wi, wa}
  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            snap_q, snap_d;
  logic [WIDTH-1:0]                lr_q, lr_d;
  logic [PV_W-1:0]                 pv_q, pv_d;
  logic [PV_W-1:0]                 gsh_q, gsh_d;
  logic [TIMESTEP*GW-1:0]          x_q, x_d;
  logic [6:0][TIMESTEP*WIDTH-1:0]  sv_q, sv_d;   // 0:t 1:h 2:c 3:a 4:i 5:f 6:o
  logic                            ready_q, ready_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  logic [6:0][WIDTH-1:0] sv_in;
  logic [PV_W-1:0]       grad_live;
  logic [CW-1:0]         el_idx;
  logic [WIDTH-1:0]      mac_w, mac_g, mac_out;
  logic                  accept;

  assign sv_in     = {i_o_s, i_f_s, i_i_s, i_a_s, i_c_s, i_h_s, i_t_s};
  assign grad_live = {i_gb, i_gwo, i_gwf, i_gwi, i_gwa};
  assign accept    = ready_q & i_valid;
  assign el_idx    = (int'(cnt_q) < NEL) ? cnt_q : '0;
  assign mac_w     = pv_q[el_idx*WIDTH +: WIDTH];
  assign mac_g     = gsh_q[el_idx*WIDTH +: WIDTH];

  fxp_mac_sub #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
    .i_w  (mac_w),
    .i_lr (lr_q),
    .i_g  (mac_g),
    .o_w  (mac_out)
  );

  // Next-state, buffer packing and weight update; outputs follow the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    lr_d    = lr_q;
    pv_d    = pv_q;
    gsh_d   = gsh_q;
    x_d     = x_q;
    sv_d    = sv_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          lr_d    = i_lr;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else if (i_wload) begin
          pv_d = {i_b_init, i_wo_init, i_wf_init, i_wi_init, i_wa_init};
        end
      end
      ST_LOAD: begin
        if (accept) begin
          x_d[cnt_q*GW +: GW] = i_x_s;
          for (int j = 0; j < 7; j++) sv_d[j][cnt_q*WIDTH +: WIDTH] = sv_in[j];
          if (cnt_q == TS_LAST) begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == ST_LAST) begin
          cnt_d   = '0;
          snap_d  = 1'b0;
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        if (!snap_q) begin
          gsh_d  = grad_live;
          snap_d = 1'b1;
        end else begin
          pv_d[el_idx*WIDTH +: WIDTH] = mac_out;
          if (cnt_q == EL_LAST) begin
            cnt_d   = '0;
            snap_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_SETTLE) || (state_d == ST_UPDATE);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers; reset clears everything including weights
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      snap_q  <= 1'b0;
      lr_q    <= '0;
      pv_q    <= '0;
      gsh_q   <= '0;
      x_q     <= '0;
      sv_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      lr_q    <= lr_d;
      pv_q    <= pv_d;
      gsh_q   <= gsh_d;
      x_q     <= x_d;
      sv_q    <= sv_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_x     = x_q;
  assign o_t     = sv_q[0];
  assign o_h     = sv_q[1];
  assign o_c     = sv_q[2];
  assign o_a     = sv_q[3];
  assign o_i     = sv_q[4];
  assign o_f     = sv_q[5];
  assign o_o     = sv_q[6];
  assign o_wa    = pv_q[GATE_A*GW +: GW];
  assign o_wi    = pv_q[GATE_I*GW +: GW];
  assign o_wf    = pv_q[GATE_F*GW +: GW];
  assign o_wo    = pv_q[GATE_O*GW +: GW];
  assign o_b     = pv_q[4*GW +: 4*WIDTH];

endmodule

// File: tb/tb_lstm_bp_ctrl.sv
// Bench for lstm_bp_ctrl with default parameters (W=32, FRAC=24, TIMESTEP=2,
// NUM=3, SETTLE=4). Honours LSTM_BP_SAT_EN for expected arithmetic results.
`timescale 1ns/1ps
module tb_lstm_bp_ctrl;

  localparam int W      = 32;
  localparam int FRAC   = 24;
  localparam int TS     = 2;
  localparam int NUM    = 3;
  localparam int SETTLE = 4;
  localparam int NEL    = 4 * (NUM + 1);
  localparam int LAT    = 1 + TS + SETTLE + NEL + 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [31:0] lr;
    logic [31:0] w;
    logic [31:0] g;
    logic [31:0] exp_wrap;
    logic [31:0] exp_sat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_done) done_cnt <= done_cnt + 1;
  end

  // ---------------- DUT signals ----------------
  logic          i_wload = 1'b0, i_start = 1'b0, i_valid = 1'b0;
  logic [31:0]   i_lr = '0;
  logic [511:0]  init_flat = '0, grad_flat = '0;
  logic [95:0]   i_wa_init, i_wi_init, i_wf_init, i_wo_init;
  logic [127:0]  i_b_init, i_gb;
  logic [95:0]   i_gwa, i_gwi, i_gwf, i_gwo;
  logic [95:0]   cur_x = '0;
  logic [31:0]   cur_v[7];
  logic          o_ready, o_busy, o_done;
  logic [191:0]  o_x;
  logic [63:0]   o_t, o_h, o_c, o_a, o_i, o_f, o_o;
  logic [95:0]   o_wa, o_wi, o_wf, o_wo;
  logic [127:0]  o_b;
  logic [511:0]  out_flat;
  logic [63:0]   o_sv[7];

  assign i_wa_init = init_flat[0 +: 96];
  assign i_wi_init = init_flat[96 +: 96];
  assign i_wf_init = init_flat[192 +: 96];
  assign i_wo_init = init_flat[288 +: 96];
  assign i_b_init  = init_flat[384 +: 128];
  assign i_gwa     = grad_flat[0 +: 96];
  assign i_gwi     = grad_flat[96 +: 96];
  assign i_gwf     = grad_flat[192 +: 96];
  assign i_gwo     = grad_flat[288 +: 96];
  assign i_gb      = grad_flat[384 +: 128];
  assign out_flat  = {o_b, o_wo, o_wf, o_wi, o_wa};
  assign o_sv[0] = o_t;
  assign o_sv[1] = o_h;
  assign o_sv[2] = o_c;
  assign o_sv[3] = o_a;
  assign o_sv[4] = o_i;
  assign o_sv[5] = o_f;
  assign o_sv[6] = o_o;

  lstm_bp_ctrl dut (
    .clk(clk), .rst(rst), .i_wload(i_wload),
    .i_wa_init(i_wa_init), .i_wi_init(i_wi_init), .i_wf_init(i_wf_init), .i_wo_init(i_wo_init),
    .i_b_init(i_b_init), .i_lr(i_lr), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_x_s(cur_x), .i_t_s(cur_v[0]), .i_h_s(cur_v[1]), .i_c_s(cur_v[2]), .i_a_s(cur_v[3]),
    .i_i_s(cur_v[4]), .i_f_s(cur_v[5]), .i_o_s(cur_v[6]),
    .o_x(o_x), .o_t(o_t), .o_h(o_h), .o_c(o_c), .o_a(o_a), .o_i(o_i), .o_f(o_f), .o_o(o_o),
    .i_gb(i_gb), .i_gwa(i_gwa), .i_gwi(i_gwi), .i_gwf(i_gwf), .i_gwo(i_gwo),
    .o_wa(o_wa), .o_wi(o_wi), .o_wf(o_wf), .o_wo(o_wo), .o_b(o_b),
    .o_busy(o_busy), .o_done(o_done)
  );

  // ---------------- reference model ----------------
  logic [95:0] smp_x[TS];
  logic [31:0] smp_v[TS][7];

  function automatic longint clamp32(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // w - (lr*g >>> FRAC), wrapped or saturated
  function automatic logic [31:0] sgd(input logic [31:0] w, input logic [31:0] lr, input logic [31:0] g);
    longint p, d;
    p = (longint'($signed(lr)) * longint'($signed(g))) >>> FRAC;
`ifdef LSTM_BP_SAT_EN
    p = clamp32(p);
    d = clamp32(longint'($signed(w)) - p);
`else
    d = longint'($signed(w)) - p;
`endif
    return d[31:0];
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive_junk();
    cur_x = {$urandom(), $urandom(), $urandom()};
    for (int j = 0; j < 7; j++) cur_v[j] = $urandom();
  endtask

  task automatic drive_sample(input int k);
    cur_x = smp_x[k];
    for (int j = 0; j < 7; j++) cur_v[j] = smp_v[k][j];
  endtask

  task automatic rand_samples();
    for (int k = 0; k < TS; k++) begin
      smp_x[k] = {$urandom(), $urandom(), $urandom()};
      for (int j = 0; j < 7; j++) smp_v[k][j] = $urandom();
    end
  endtask

  task automatic rand_init_grad();
    for (int e = 0; e < NEL; e++) begin
      init_flat[e*32 +: 32] = $urandom();
      grad_flat[e*32 +: 32] = $urandom();
    end
  endtask

  task automatic wload_check(input string tag);
    i_wload = 1'b1;
    tick();
    i_wload = 1'b0;
    chk({tag, "_wload"}, out_flat, init_flat);
  endtask

  // Pushes the model's result for every element using current init/grad/lr
  task automatic push_model(input logic [31:0] lr);
    for (int e = 0; e < NEL; e++)
      exp_q.push_back(sgd(init_flat[e*32 +: 32], lr, grad_flat[e*32 +: 32]));
  endtask

  task automatic check_weights(input string tag);
    logic [31:0] exp;
    for (int e = 0; e < NEL; e++) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_q_empty act=0 exp=%0d", tag, NEL);
        return;
      end
      exp = exp_q.pop_front();
      chk($sformatf("%s_w%0d", tag, e), out_flat[e*32 +: 32], exp);
    end
  endtask

  task automatic check_pack(input string tag);
    chk({tag, "_x"}, o_x, {smp_x[1], smp_x[0]});
    for (int j = 0; j < 7; j++)
      chk($sformatf("%s_s%0d", tag, j), o_sv[j], {smp_v[1][j], smp_v[0][j]});
  endtask

  // One full window; lat returns cycles from i_start to o_done (-1 on timeout)
  task automatic run_window(input bit gaps, input bit scramble, input bit glitch,
                            input logic [31:0] lr, output int lat);
    int s, guard, d0;
    bit ok, first;
    lat = -1;
    d0 = done_cnt;
    i_lr = lr;
    i_start = 1'b1;
    s = cyc;
    tick();
    i_start = 1'b0;
    i_wload = 1'b0;
    i_lr = $urandom();
    for (int k = 0; k < TS; k++) begin
      ok = 1'b0;
      guard = 0;
      while (!ok && guard < 50) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          i_valid = 1'b0;
          drive_junk();
        end else begin
          i_valid = 1'b1;
          drive_sample(k);
        end
        ok = i_valid && o_ready;
        tick();
        guard++;
      end
      if (!ok) begin
        errors++;
        $display("FAIL load_timeout act=%0d exp=%0d", k, TS);
        i_valid = 1'b0;
        return;
      end
    end
    i_valid = 1'b1;
    drive_junk();
    chk("ready_drop", o_ready, 1'b0);
    guard = 0;
    first = 1'b1;
    while (!o_done && guard < 200) begin
      i_start = glitch && first;
      first = 1'b0;
      tick();
      guard++;
      i_start = 1'b0;
      if (scramble && (cyc - s == 8)) begin
        for (int e = 0; e < NEL; e++) grad_flat[e*32 +: 32] = $urandom();
      end
    end
    i_valid = 1'b0;
    if (!o_done) begin
      errors++;
      $display("FAIL done_timeout act=%0d exp=%0d", guard, LAT);
      return;
    end
    lat = cyc - s;
    tick();
    chk("done_width", o_done, 1'b0);
    chk("busy_after", o_busy, 1'b0);
    chk("done_count", done_cnt, d0 + 1);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  int   lat;

  initial begin
    vecs[0] = '{32'h00100000, 32'h00800000, 32'h01000000, 32'h00700000, 32'h00700000};
    vecs[1] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000100, 32'h80000000};
    vecs[2] = '{32'h01000000, 32'h00000000, 32'hFF000000, 32'h01000000, 32'h01000000};
    vecs[3] = '{32'h00000001, 32'h00000010, 32'hFFFFFFFF, 32'h00000011, 32'h00000011};
    vecs[4] = '{32'h00000001, 32'h00000005, 32'h00000001, 32'h00000005, 32'h00000005};
    vecs[5] = '{32'h01000000, 32'h7FFFFFFF, 32'hFF000000, 32'h80FFFFFF, 32'h7FFFFFFF};
    for (int j = 0; j < 7; j++) cur_v[j] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_weights", out_flat, '0);
    chk("rst_x", o_x, '0);
    chk("rst_t", o_t, '0);
    rst = 1'b0;
    tick();

    // Load/pack, exact latency, gradient shadow, i_start beating i_wload
    rand_init_grad();
    wload_check("pack");
    rand_samples();
    smp_v[0][0] = 32'h00800000;
    smp_v[1][0] = 32'h01400000;
    push_model(32'h00200000);
    for (int e = 0; e < NEL; e++) init_flat[e*32 +: 32] = $urandom();
    i_wload = 1'b1;
    run_window(1'b0, 1'b1, 1'b0, 32'h00200000, lat);
    chk("latency", lat, LAT);
    chk("pack_t_const", o_t, 64'h01400000_00800000);
    check_pack("pack");
    check_weights("pack");

    // Table vectors: one non-zero gradient, every other element must hold
    for (int i = 0; i < 6; i++) begin
      int sel;
      logic [31:0] exp_v;
      sel = (i * 5 + 3) % NEL;
      for (int e = 0; e < NEL; e++) begin
        init_flat[e*32 +: 32] = $urandom();
        grad_flat[e*32 +: 32] = '0;
      end
      init_flat[sel*32 +: 32] = vecs[i].w;
      grad_flat[sel*32 +: 32] = vecs[i].g;
`ifdef LSTM_BP_SAT_EN
      exp_v = vecs[i].exp_sat;
`else
      exp_v = vecs[i].exp_wrap;
`endif
      wload_check($sformatf("vec%0d", i));
      for (int e = 0; e < NEL; e++)
        exp_q.push_back((e == sel) ? exp_v : init_flat[e*32 +: 32]);
      rand_samples();
      run_window(i[0], 1'b0, (i == 2), vecs[i].lr, lat);
      check_weights($sformatf("vec%0d", i));
    end

    // Randomized windows with valid gaps and ignored mid-window starts
    for (int r = 0; r < 6; r++) begin
      logic [31:0] lr;
      rand_init_grad();
      lr = $urandom_range(0, 1) ? $urandom_range(0, 32'h02000000) : $urandom();
      wload_check($sformatf("rnd%0d", r));
      rand_samples();
      push_model(lr);
      run_window(1'b1, 1'b0, $urandom_range(0, 1), lr, lat);
      check_pack($sformatf("rnd%0d", r));
      check_weights($sformatf("rnd%0d", r));
    end

    // Reset in the middle of UPDATE
    begin
      int s, d0, guard;
      rand_init_grad();
      wload_check("mid");
      rand_samples();
      i_lr = 32'h00100000;
      i_start = 1'b1;
      s = cyc;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < TS; k++) begin
        i_valid = 1'b1;
        drive_sample(k);
        tick();
      end
      i_valid = 1'b0;
      guard = 0;
      while (cyc - s < 12 && guard < 40) begin
        tick();
        guard++;
      end
      chk("mid_busy_before", o_busy, 1'b1);
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", o_busy, 1'b0);
      chk("mid_rst_ready", o_ready, 1'b0);
      chk("mid_rst_done", o_done, 1'b0);
      chk("mid_rst_weights", out_flat, '0);
      chk("mid_rst_x", o_x, '0);
      chk("mid_rst_t", o_t, '0);
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("mid_no_done", done_cnt, d0);
      chk("mid_idle_busy", o_busy, 1'b0);
      chk("mid_idle_weights", out_flat, '0);
    end

    // Recovery window after the abort
    rand_init_grad();
    wload_check("post");
    rand_samples();
    push_model(32'h00080000);
    run_window(1'b0, 1'b0, 1'b0, 32'h00080000, lat);
    chk("post_latency", lat, LAT);
    check_pack("post");
    check_weights("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound on simulation time
  initial begin
    #500000;
    $display("FAIL watchdog act=%0d exp=%0d", cyc, 0);
    $fatal(1, "watchdog expired");
  end

endmodule
